ex_muldiv_iter: RTL

//  Iterative multiply/divide unit for the execute stage, producing a {HI,LO} result pair.

---
 rtl/ex_muldiv_iter.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/ex_muldiv_iter.sv
// ex_muldiv_iter: iterative multiply/divide unit for the execute stage.
// MULT/MULTU use shift-add, DIV/DIVU use restoring division, one result bit
// per cycle. Signed operations run on magnitudes and are sign-corrected in a
// single FIX cycle. A stall request holds the pipeline while the unit works.
module ex_muldiv_iter #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [1:0]    op_i,
  input  logic [DW-1:0] opa_i,
  input  logic [DW-1:0] opb_i,
  input  logic          annul_i,
  output logic          stall_req_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          div_zero_o,
  output logic [DW-1:0] hi_o,
  output logic [DW-1:0] lo_o
);

  // Iteration counter width; derived from DW and not meant to be overridden.
  localparam int CW = $clog2(DW) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // op_i[1] selects divide, op_i[0] selects unsigned.
  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            is_div_q, is_div_d;
  logic            is_signed_q, is_signed_d;
  logic            sign_a_q, sign_a_d;
  logic            sign_b_q, sign_b_d;
  logic [DW-1:0]   a_q, a_d;
  logic [DW-1:0]   b_q, b_d;
  logic [2*DW-1:0] acc_q, acc_d;
  logic [DW-1:0]   hi_q, hi_d;
  logic [DW-1:0]   lo_q, lo_d;
  logic            dz_q, dz_d;

  logic            accept;
  logic            req_signed;
  logic            req_div_zero;
  logic            opa_neg, opb_neg;
  logic [DW-1:0]   opa_mag, opb_mag;

  logic [DW:0]     mul_sum;
  logic [2*DW-1:0] mul_next;
  logic [DW:0]     div_rem_sh;
  logic            div_ge;
  logic [DW-1:0]   div_rem_new;
  logic [2*DW-1:0] div_next;
  logic [2*DW-1:0] fixed;

  // Request decode and operand magnitudes, evaluated only while IDLE.
  always_comb begin
    accept       = (state_q == S_IDLE) && start_i && !annul_i;
    req_signed   = !op_i[0];
    req_div_zero = op_i[1] && (opb_i == '0);
    opa_neg      = req_signed && opa_i[DW-1];
    opb_neg      = req_signed && opb_i[DW-1];
    // The most-negative input negates to itself, which is the correct
    // DW-bit unsigned magnitude.
    opa_mag      = opa_neg ? -opa_i : opa_i;
    opb_mag      = opb_neg ? -opb_i : opb_i;
  end

  // One iteration step for each algorithm plus the signed correction.
  always_comb begin
    // Multiply: add the multiplicand when the multiplier LSB is set, then
    // shift the {partial, multiplier} accumulator right by one.
    mul_sum  = {1'b0, acc_q[2*DW-1:DW]} + (acc_q[0] ? {1'b0, a_q} : '0);
    mul_next = {mul_sum, acc_q[DW-1:1]};

    // Divide: shift {rem, quo} left, subtract the divisor when it fits.
    // The remainder is always below the divisor, so the difference fits
    // in DW bits even when the shifted value overflows into bit DW.
    div_rem_sh  = acc_q[2*DW-1:DW-1];
    div_ge      = div_rem_sh >= {1'b0, b_q};
    div_rem_new = div_ge ? (div_rem_sh[DW-1:0] - b_q) : div_rem_sh[DW-1:0];
    div_next    = {div_rem_new, acc_q[DW-2:0], div_ge};

    // Sign correction: product negated on differing signs; quotient negated
    // on differing signs, remainder follows the dividend.
    fixed = acc_q;
    if (is_signed_q) begin
      if (!is_div_q) begin
        if (sign_a_q ^ sign_b_q) fixed = -acc_q;
      end else begin
        fixed[2*DW-1:DW] = sign_a_q ? -acc_q[2*DW-1:DW] : acc_q[2*DW-1:DW];
        fixed[DW-1:0]    = (sign_a_q ^ sign_b_q) ? -acc_q[DW-1:0] : acc_q[DW-1:0];
      end
    end
  end

  // Control: next state, iteration counter and handshake outputs.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_req_o = 1'b0;
    busy_o      = (state_q != S_IDLE);
    done_o      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        stall_req_o = accept;
        if (accept) begin
          cnt_d   = '0;
          state_d = req_div_zero ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        stall_req_o = 1'b1;
        if (annul_i) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(DW - 1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        stall_req_o = 1'b1;
        state_d     = annul_i ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next-state: operand capture, iteration and result commit.
  always_comb begin
    is_div_d    = is_div_q;
    is_signed_d = is_signed_q;
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    dz_d        = dz_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          is_div_d    = op_i[1];
          is_signed_d = req_signed;
          sign_a_d    = opa_neg;
          sign_b_d    = opb_neg;
          a_d         = opa_mag;
          b_d         = opb_mag;
          // Multiply seeds the low half with the multiplier; divide seeds
          // it with the dividend.
          acc_d       = op_i[1] ? {{DW{1'b0}}, opa_mag} : {{DW{1'b0}}, opb_mag};
          if (req_div_zero) begin
            hi_d = opa_i;
            lo_d = '1;
            dz_d = 1'b1;
          end
        end
      end
      S_CALC: begin
        if (!annul_i) acc_d = is_div_q ? div_next : mul_next;
      end
      S_FIX: begin
        if (!annul_i) begin
          acc_d = fixed;
          hi_d  = fixed[2*DW-1:DW];
          lo_d  = fixed[DW-1:0];
          dz_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Datapath and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      is_div_q    <= 1'b0;
      is_signed_q <= 1'b0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      dz_q        <= 1'b0;
    end else begin
      is_div_q    <= is_div_d;
      is_signed_q <= is_signed_d;
      sign_a_q    <= sign_a_d;
      sign_b_q    <= sign_b_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      dz_q        <= dz_d;
    end
  end

  // Results hold between operations; the divide-by-zero flag is only
  // presented alongside done_o.
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;
  assign div_zero_o = dz_q && (state_q == S_DONE);

endmodule
